branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences control-flow changes for the five-stage pipeline. Samples the EX-stage branch/jump resolution once per instruction, decides taken/not-taken, and drives a registered PC redirect to fetch plus squash signals for the wrong-path IF/ID, ID/EX and EX/MEM contents. Holds the redirect until fetch accepts it, so a busy instruction memory cannot drop a redirect.

## Interface
Parameters:
- `ADDR_W`, 16: PC / target width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `ex_valid`  in  1  EX holds a real (non-bubble) instruction.
- `ex_stall`  in  1  EX is held this cycle. A resolution is not sampled while stalled.
- `ex_is_cf`  in  1  EX instruction is a branch or jump.
- `ex_type`  in  3  condition code: 000 beqz, 001 bnez, 010 bltz, 011 bgez, 100 jump; 101–111 never taken.
- `ex_sign`  in  1  sign bit of the tested register.
- `ex_zero`  in  1  tested register == 0.
- `ex_target`  in  ADDR_W  resolved target PC.
- `fetch_ready`  in  1  fetch accepts a redirect this cycle.
- `redir_valid`  out  1  redirect request to fetch (registered).
- `redir_pc`  out  ADDR_W  redirect target (registered).
- `flush_if`, `flush_id`, `flush_ex`  out  1 each  squash the IF/ID, ID/EX and EX/MEM pipeline registers. All three equal `redir_valid`.
- `busy`  out  1  state != IDLE.
- `br_count`, `taken_count`, `flush_cycles`  out  16 each  statistics. Present only with `BRANCH_STATS_EN`.

## Operation
Sample condition:
- `sample = ex_valid & ex_is_cf & ~ex_stall & ~redir_valid`.

Taken decision:
- `taken = (type==100) | (type==011 & ~sign) | (type==010 & sign) | (type==001 & ~zero) | (type==000 & zero)`.

FSM, two states:
- **IDLE**
  - `sample & taken`: load `redir_pc <= ex_target`, set `redir_valid`, go to PEND.
  - `sample & ~taken`: no action, stay in IDLE.
- **PEND**
  - `redir_valid` and all flushes held high; `redir_pc` held stable.
  - `fetch_ready=1`: clear `redir_valid` and return to IDLE at the next edge.
  - `fetch_ready=0`: stay in PEND; flushes stay high every cycle.
  - EX inputs are ignored. Anything in EX during PEND is wrong-path.

Reset (`rst_n=0` at an edge):
- State IDLE; `redir_valid=0`, `redir_pc=0`, all flushes 0, `busy=0`, statistics 0.
- Applies even mid-PEND; the pending redirect is discarded.

## Timing
- Resolution sampled at edge N produces `redir_valid=1` and flushes in cycle N+1. Latency is 1 cycle; there is no combinational path from EX to the outputs.
- Minimum redirect pulse is 1 cycle, when `fetch_ready=1` in N+1.
- Each cycle of `fetch_ready=0` adds one cycle of PEND.
- A taken resolution during a stall is sampled on the first cycle with `ex_stall=0`, exactly once.
- Back-to-back control-flow instructions:
  - The one in EX at N+1 is ignored (squashed).
  - The next resolution can be sampled no earlier than the cycle after `redir_valid` falls.
- `redir_valid` and `redir_pc` never change while `redir_valid=1 & fetch_ready=0`. Fetch relies on this.

## Configuration
`BRANCH_STATS_EN` defined:
- `br_count` increments on every `sample`.
- `taken_count` increments on `sample & taken`.
- `flush_cycles` increments on every cycle with `redir_valid=1`.
- All three counters saturate at 16'hFFFF and reset to 0.

`BRANCH_STATS_EN` undefined:
- Counter ports and logic are absent.
- Control behaviour is cycle-identical to the defined case.

## Test plan
- beqz, `ex_zero=1`, `ex_target=16'h0040`, `fetch_ready=1`: `redir_valid`/flushes high for exactly 1 cycle at N+1, `redir_pc=16'h0040`, then IDLE.
- bnez with `ex_zero=1`, and bltz with `ex_sign=0`: no redirect, no flush. Stats build: `br_count=2`, `taken_count=0`.
- Jump to 16'h1234, `fetch_ready=0` for 3 cycles then 1: redirect and flushes high for 4 cycles, `redir_pc` stable at 16'h1234, `flush_cycles=4`.
- Taken bgez held with `ex_stall=1` for 2 cycles, then released: a single redirect 1 cycle after release; `br_count` increments by 1 only.
- Taken branch, then a taken jump in EX at N+1: the jump is ignored, and `redir_pc` keeps the first target.
- `rst_n=0` during PEND with `fetch_ready=0`: the cycle after the reset edge, `redir_valid=0`, `busy=0`, counters 0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer: registers a taken EX resolution into a PC redirect plus pipeline squashes, held until fetch accepts.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic              ex_is_cf,
    input  logic [2:0]        ex_type,
    input  logic              ex_sign,
    input  logic              ex_zero,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              fetch_ready,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    output logic              flush_if,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]       br_count,
    output logic [15:0]       taken_count,
    output logic [15:0]       flush_cycles
`endif
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state_q, state_d;
    logic               redir_valid_q, redir_valid_d;
    logic [ADDR_W-1:0]  redir_pc_q, redir_pc_d;
    logic               sample;
    logic               taken;

    // An outstanding redirect blocks sampling: whatever sits in EX is wrong-path.
    assign sample = ex_valid & ex_is_cf & ~ex_stall & ~redir_valid_q;

    always_comb begin
        taken = 1'b0;
        case (ex_type)
            3'b000:  taken = ex_zero;
            3'b001:  taken = ~ex_zero;
            3'b010:  taken = ex_sign;
            3'b011:  taken = ~ex_sign;
            3'b100:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        case (state_q)
            IDLE: begin
                if (sample && taken) begin
                    state_d       = PEND;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = ex_target;
                end
            end
            PEND: begin
                if (fetch_ready) begin
                    state_d       = IDLE;
                    redir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                redir_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
        end
    end

    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign flush_if    = redir_valid_q;
    assign flush_id    = redir_valid_q;
    assign flush_ex    = redir_valid_q;
    assign busy        = (state_q != IDLE);

`ifdef BRANCH_STATS_EN
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] taken_count_q, taken_count_d;
    logic [15:0] flush_cycles_q, flush_cycles_d;

    // All counters saturate rather than wrap.
    always_comb begin
        br_count_d     = br_count_q;
        taken_count_d  = taken_count_q;
        flush_cycles_d = flush_cycles_q;
        if (sample && br_count_q != 16'hFFFF)
            br_count_d = br_count_q + 16'd1;
        if (sample && taken && taken_count_q != 16'hFFFF)
            taken_count_d = taken_count_q + 16'd1;
        if (redir_valid_q && flush_cycles_q != 16'hFFFF)
            flush_cycles_d = flush_cycles_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_count_q     <= '0;
            taken_count_q  <= '0;
            flush_cycles_q <= '0;
        end else begin
            br_count_q     <= br_count_d;
            taken_count_q  <= taken_count_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign br_count     = br_count_q;
    assign taken_count  = taken_count_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed scoreboard bench for branch_redirect_ctrl; expected outputs are queued per driven step and checked after the edge.
module tb_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_stall, ex_is_cf, ex_sign, ex_zero, fetch_ready;
    logic [2:0]  ex_type;
    logic [15:0] ex_target;
    logic        redir_valid, flush_if, flush_id, flush_ex, busy;
    logic [15:0] redir_pc;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_count, taken_count, flush_cycles;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        string       tag;
        logic        v;
        logic [15:0] pc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_is_cf(ex_is_cf),
        .ex_type(ex_type), .ex_sign(ex_sign), .ex_zero(ex_zero),
        .ex_target(ex_target), .fetch_ready(fetch_ready),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .busy(busy)
`ifdef BRANCH_STATS_EN
        , .br_count(br_count), .taken_count(taken_count), .flush_cycles(flush_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then check them.
    task automatic step(input string tag, input logic rst, input logic vld, input logic stl,
                        input logic cf, input logic [2:0] typ, input logic sgn, input logic zro,
                        input logic [15:0] tgt, input logic fr,
                        input logic exp_v, input logic [15:0] exp_pc);
        exp_t e;
        rst_n = rst; ex_valid = vld; ex_stall = stl; ex_is_cf = cf; ex_type = typ;
        ex_sign = sgn; ex_zero = zro; ex_target = tgt; fetch_ready = fr;
        e.tag = tag; e.v = exp_v; e.pc = exp_pc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".valid"}, {31'd0, redir_valid}, {31'd0, e.v});
        chk({e.tag, ".busy"},  {31'd0, busy},        {31'd0, e.v});
        chk({e.tag, ".flush"}, {29'd0, flush_if, flush_id, flush_ex}, {29'd0, {3{e.v}}});
        if (e.v) chk({e.tag, ".pc"}, {16'd0, redir_pc}, {16'd0, e.pc});
        $display("step %s: valid=%0b pc=%h busy=%0b", e.tag, redir_valid, redir_pc, busy);
    endtask

    task automatic idle(input string tag, input logic fr, input logic exp_v, input logic [15:0] exp_pc);
        step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, fr, exp_v, exp_pc);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
        chk({tag, ".pc0"}, {16'd0, redir_pc}, 32'd0);
    endtask

`ifdef BRANCH_STATS_EN
    task automatic stats(input string tag, input int br, input int tk, input int fc);
        chk({tag, ".br_count"},     {16'd0, br_count},     br);
        chk({tag, ".taken_count"},  {16'd0, taken_count},  tk);
        chk({tag, ".flush_cycles"}, {16'd0, flush_cycles}, fc);
    endtask
`endif

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_stall = 1'b0; ex_is_cf = 1'b0; ex_type = 3'b000;
        ex_sign = 1'b0; ex_zero = 1'b0; ex_target = 16'h0000; fetch_ready = 1'b1;
        do_reset("rst_a");
        do_reset("rst_b");
`ifdef BRANCH_STATS_EN
        stats("rst", 0, 0, 0);
`endif

        // Taken beqz, fetch accepts immediately: one-cycle redirect pulse.
        step("beqz", 1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 16'h0040);
        idle("beqz_end", 1'b1, 1'b0, 16'h0000);
        idle("beqz_idle", 1'b1, 1'b0, 16'h0000);

        // Not-taken bnez and bltz.
        do_reset("rst_nt");
        step("bnez_nt", 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b1, 16'h0080, 1'b1, 1'b0, 16'h0000);
        step("bltz_nt", 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 16'h00C0, 1'b1, 1'b0, 16'h0000);
        step("t5_nt",   1'b1, 1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 1'b1, 16'h00E0, 1'b1, 1'b0, 16'h0000);
        step("notcf",   1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 16'h00F0, 1'b1, 1'b0, 16'h0000);
`ifdef BRANCH_STATS_EN
        stats("nt", 3, 0, 0);
`endif

        // Jump with fetch busy for three cycles; EX contents during PEND ignored.
        do_reset("rst_j");
        step("jmp",    1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 16'h1234);
        step("jmp_w1", 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b1, 16'h1234);
        idle("jmp_w2", 1'b0, 1'b1, 16'h1234);
        idle("jmp_w3", 1'b0, 1'b1, 16'h1234);
        idle("jmp_acc", 1'b1, 1'b0, 16'h0000);
`ifdef BRANCH_STATS_EN
        stats("jmp", 1, 1, 4);
`endif

        // Taken bgez held by a stall for two cycles.
        do_reset("rst_s");
        step("bgez_s1", 1'b1, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 16'h0A00, 1'b1, 1'b0, 16'h0000);
        step("bgez_s2", 1'b1, 1'b1, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 16'h0A00, 1'b1, 1'b0, 16'h0000);
        step("bgez_go", 1'b1, 1'b1, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 16'h0A00, 1'b1, 1'b1, 16'h0A00);
        idle("bgez_end", 1'b1, 1'b0, 16'h0000);
`ifdef BRANCH_STATS_EN
        stats("stall", 1, 1, 1);
`endif

        // Back-to-back: taken bltz then a taken jump squashed at N+1.
        do_reset("rst_b2b");
        step("b2b_br",  1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0100, 1'b1, 1'b1, 16'h0100);
        step("b2b_jmp", 1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 16'h0200, 1'b1, 1'b0, 16'h0000);
        idle("b2b_idle", 1'b1, 1'b0, 16'h0000);
        chk("b2b.pc_kept", {16'd0, redir_pc}, 32'h0100);

        // Reset in the middle of PEND discards the redirect.
        do_reset("rst_p");
        step("p_jmp",  1'b1, 1'b1, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b1, 16'h0F0F);
        idle("p_wait", 1'b0, 1'b1, 16'h0F0F);
        step("p_rst",  1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        chk("p_rst.pc0", {16'd0, redir_pc}, 32'd0);
`ifdef BRANCH_STATS_EN
        stats("p_rst", 0, 0, 0);
`endif
        idle("p_after", 1'b0, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
